// File: rtl/adder_result_checker_if.sv
// Bundle between an adder test harness and the result checker: stimulus, both
// adders' results, and the checker's run status and first-failure record.
interface adder_result_checker_if #(
    parameter int N     = 32,
    parameter int CNT_W = 32
);
    // stimulus and results as seen by the checker
    logic             start;
    logic             valid;
    logic             cin;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [N-1:0]     s_ref;
    logic [N-1:0]     s_duv;
    logic             cout_ref;
    logic             cout_duv;
    logic             prop_ref;
    logic             gen_ref;
    logic             prop_duv;
    logic             gen_duv;

    // status and first-failure record
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] vec_count;
    logic [CNT_W-1:0] err_count;
    logic             first_err_valid;
    logic [CNT_W-1:0] first_err_index;
    logic [N-1:0]     first_err_a;
    logic [N-1:0]     first_err_b;
    logic             first_err_cin;
    logic [N-1:0]     first_err_s_duv;
    logic [N-1:0]     first_err_s_ref;

    modport master (
        output start, valid, cin, a, b, s_ref, s_duv, cout_ref, cout_duv,
               prop_ref, gen_ref, prop_duv, gen_duv,
        input  busy, done, pass, vec_count, err_count, first_err_valid,
               first_err_index, first_err_a, first_err_b, first_err_cin,
               first_err_s_duv, first_err_s_ref
    );

    modport slave (
        input  start, valid, cin, a, b, s_ref, s_duv, cout_ref, cout_duv,
               prop_ref, gen_ref, prop_duv, gen_duv,
        output busy, done, pass, vec_count, err_count, first_err_valid,
               first_err_index, first_err_a, first_err_b, first_err_cin,
               first_err_s_duv, first_err_s_ref
    );
endinterface

// File: rtl/adder_result_checker.sv
// Compares a DUV adder against a reference adder vector by vector, counts
// vectors and mismatches, and latches the first failing vector of a run.
module adder_result_checker #(
    parameter int N           = 32,
    parameter int TYPE        = 0,
    parameter int NUM_VECTORS = 30000,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adder_result_checker_if.slave chk
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [CNT_W-1:0] vec_q;
    logic [CNT_W-1:0] err_q;
    logic             fev_q;
    logic [CNT_W-1:0] fidx_q;
    logic [N-1:0]     fa_q;
    logic [N-1:0]     fb_q;
    logic             fcin_q;
    logic [N-1:0]     fsduv_q;
    logic [N-1:0]     fsref_q;

    logic             mm;
    logic [CNT_W-1:0] vec_d;
    logic [CNT_W-1:0] err_d;
    logic             last_vec;

    // Case inequality so that X/Z on a DUV output reads as a mismatch in
    // simulation; synthesis treats it as an ordinary compare.
    always_comb begin
        mm = (chk.s_duv !== chk.s_ref) | (chk.cout_duv !== chk.cout_ref);
        if (TYPE == 1)
            mm = mm | (chk.prop_duv !== chk.prop_ref) | (chk.gen_duv !== chk.gen_ref);
        vec_d    = vec_q + CNT_W'(1);
        err_d    = (mm && (err_q != CNT_MAX)) ? err_q + CNT_W'(1) : err_q;
        last_vec = (vec_d == LAST_VEC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            vec_q   <= '0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fidx_q  <= '0;
            fa_q    <= '0;
            fb_q    <= '0;
            fcin_q  <= 1'b0;
            fsduv_q <= '0;
            fsref_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // a new run starts from a clean slate; valid is ignored here
                    if (chk.start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        vec_q   <= '0;
                        err_q   <= '0;
                        fev_q   <= 1'b0;
                        fidx_q  <= '0;
                        fa_q    <= '0;
                        fb_q    <= '0;
                        fcin_q  <= 1'b0;
                        fsduv_q <= '0;
                        fsref_q <= '0;
                    end
                end
                RUN: begin
                    if (chk.valid) begin
                        vec_q <= vec_d;
                        err_q <= err_d;
                        if (mm && !fev_q) begin
                            fev_q   <= 1'b1;
                            fidx_q  <= vec_q;
                            fa_q    <= chk.a;
                            fb_q    <= chk.b;
                            fcin_q  <= chk.cin;
                            fsduv_q <= chk.s_duv;
                            fsref_q <= chk.s_ref;
                        end
                        // the final vector's own mismatch feeds pass via err_d
                        if (last_vec) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign chk.busy            = busy_q;
    assign chk.done            = done_q;
    assign chk.pass            = pass_q;
    assign chk.vec_count       = vec_q;
    assign chk.err_count       = err_q;
    assign chk.first_err_valid = fev_q;
    assign chk.first_err_index = fidx_q;
    assign chk.first_err_a     = fa_q;
    assign chk.first_err_b     = fb_q;
    assign chk.first_err_cin   = fcin_q;
    assign chk.first_err_s_duv = fsduv_q;
    assign chk.first_err_s_ref = fsref_q;
endmodule

// File: tb/tb_adder_result_checker.sv
// Drives two checkers (prop/gen checked and not) with the same random vector
// stream and compares them against a list-based model of each run.
module tb_adder_result_checker;
    localparam int N  = 32;
    localparam int CW = 32;
    localparam int NV = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         start = 1'b0, valid = 1'b0, cin = 1'b0;
    logic [N-1:0] a = '0, b = '0, s_ref = '0, s_duv = '0;
    logic         cout_ref = 1'b0, cout_duv = 1'b0;
    logic         prop_ref = 1'b0, gen_ref = 1'b0, prop_duv = 1'b0, gen_duv = 1'b0;

    adder_result_checker_if #(.N(N), .CNT_W(CW)) bus1 ();
    adder_result_checker_if #(.N(N), .CNT_W(CW)) bus0 ();

    assign bus1.start = start;       assign bus0.start = start;
    assign bus1.valid = valid;       assign bus0.valid = valid;
    assign bus1.cin = cin;           assign bus0.cin = cin;
    assign bus1.a = a;               assign bus0.a = a;
    assign bus1.b = b;               assign bus0.b = b;
    assign bus1.s_ref = s_ref;       assign bus0.s_ref = s_ref;
    assign bus1.s_duv = s_duv;       assign bus0.s_duv = s_duv;
    assign bus1.cout_ref = cout_ref; assign bus0.cout_ref = cout_ref;
    assign bus1.cout_duv = cout_duv; assign bus0.cout_duv = cout_duv;
    assign bus1.prop_ref = prop_ref; assign bus0.prop_ref = prop_ref;
    assign bus1.gen_ref = gen_ref;   assign bus0.gen_ref = gen_ref;
    assign bus1.prop_duv = prop_duv; assign bus0.prop_duv = prop_duv;
    assign bus1.gen_duv = gen_duv;   assign bus0.gen_duv = gen_duv;

    adder_result_checker #(.N(N), .TYPE(1), .NUM_VECTORS(NV), .CNT_W(CW)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .chk(bus1.slave));
    adder_result_checker #(.N(N), .TYPE(0), .NUM_VECTORS(NV), .CNT_W(CW)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .chk(bus0.slave));

    typedef struct {
        logic [N-1:0] a, b, s_ref, s_duv;
        logic         cin, cout_ref, cout_duv, pr, gr, pd, gd;
    } vec_t;

    vec_t run_q[$];
    bit   in_run = 1'b0;
    int   errs = 0, checks = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // kind: 0 clean, 1 sum bit flip, 2 cout flip, 3 prop flip, 4 gen flip
    function automatic vec_t mk_vec(int kind);
        vec_t v;
        logic [N:0] sum;
        v.a   = $urandom;
        v.b   = $urandom;
        v.cin = 1'($urandom_range(0, 1));
        sum = {1'b0, v.a} + {1'b0, v.b} + (N+1)'(v.cin);
        v.s_ref = sum[N-1:0];
        v.cout_ref = sum[N];
        v.pr = 1'($urandom_range(0, 1));
        v.gr = 1'($urandom_range(0, 1));
        v.s_duv = v.s_ref; v.cout_duv = v.cout_ref; v.pd = v.pr; v.gd = v.gr;
        case (kind)
            1: v.s_duv = v.s_ref ^ (32'h1 << $urandom_range(0, N-1));
            2: v.cout_duv = ~v.cout_ref;
            3: v.pd = ~v.pr;
            4: v.gd = ~v.gr;
            default: ;
        endcase
        return v;
    endfunction

    function automatic bit is_mm(vec_t v, int t);
        return (v.s_duv != v.s_ref) || (v.cout_duv != v.cout_ref) ||
               (t == 1 && ((v.pd != v.pr) || (v.gd != v.gr)));
    endfunction

    task automatic put(vec_t v, bit vld, bit st);
        a = v.a; b = v.b; cin = v.cin; s_ref = v.s_ref; s_duv = v.s_duv;
        cout_ref = v.cout_ref; cout_duv = v.cout_duv;
        prop_ref = v.pr; gen_ref = v.gr; prop_duv = v.pd; gen_duv = v.gd;
        valid = vld; start = st;
        if (vld && in_run) begin
            run_q.push_back(v);
            if (run_q.size() == NV) in_run = 1'b0;
        end
    endtask

    task automatic drive(vec_t v, bit vld, bit st = 1'b0);
        @(negedge clk);
        put(v, vld, st);
    endtask

    task automatic do_start();
        @(negedge clk);
        put(mk_vec(1), 1'b0, 1'b1);
        run_q.delete();
        in_run = 1'b1;
    endtask

    task automatic check_state(string tag, int t);
        logic [CW-1:0] vc, ec, fi;
        logic          bz, dn, ps, fv, fc;
        logic [N-1:0]  fa, fb, fsd, fsr;
        int e_err, e_idx;
        bit e_fv, e_done;
        vec_t e_v;
        if (t == 1) begin
            vc = bus1.vec_count; ec = bus1.err_count; fi = bus1.first_err_index;
            bz = bus1.busy; dn = bus1.done; ps = bus1.pass; fv = bus1.first_err_valid;
            fc = bus1.first_err_cin; fa = bus1.first_err_a; fb = bus1.first_err_b;
            fsd = bus1.first_err_s_duv; fsr = bus1.first_err_s_ref;
        end else begin
            vc = bus0.vec_count; ec = bus0.err_count; fi = bus0.first_err_index;
            bz = bus0.busy; dn = bus0.done; ps = bus0.pass; fv = bus0.first_err_valid;
            fc = bus0.first_err_cin; fa = bus0.first_err_a; fb = bus0.first_err_b;
            fsd = bus0.first_err_s_duv; fsr = bus0.first_err_s_ref;
        end
        e_err = 0; e_idx = 0; e_fv = 1'b0;
        e_v = '{default: '0};
        foreach (run_q[i])
            if (is_mm(run_q[i], t)) begin
                e_err++;
                if (!e_fv) begin e_fv = 1'b1; e_idx = i; e_v = run_q[i]; end
            end
        e_done = (run_q.size() == NV);
        chk($sformatf("%s.t%0d.vec", tag, t), vc, run_q.size());
        chk($sformatf("%s.t%0d.err", tag, t), ec, e_err);
        chk($sformatf("%s.t%0d.busy", tag, t), bz, !e_done);
        chk($sformatf("%s.t%0d.done", tag, t), dn, e_done);
        chk($sformatf("%s.t%0d.pass", tag, t), ps, e_done && e_err == 0);
        chk($sformatf("%s.t%0d.fev", tag, t), fv, e_fv);
        chk($sformatf("%s.t%0d.fidx", tag, t), fi, e_idx);
        chk($sformatf("%s.t%0d.fa", tag, t), fa, e_v.a);
        chk($sformatf("%s.t%0d.fb", tag, t), fb, e_v.b);
        chk($sformatf("%s.t%0d.fcin", tag, t), fc, e_v.cin);
        chk($sformatf("%s.t%0d.fsduv", tag, t), fsd, e_v.s_duv);
        chk($sformatf("%s.t%0d.fsref", tag, t), fsr, e_v.s_ref);
    endtask

    task automatic check_zero(string tag);
        chk({tag, ".out1"}, {bus1.busy, bus1.done, bus1.pass, bus1.first_err_valid,
            bus1.first_err_cin, |bus1.vec_count, |bus1.err_count, |bus1.first_err_index,
            |bus1.first_err_a, |bus1.first_err_b, |bus1.first_err_s_duv, |bus1.first_err_s_ref}, 0);
        chk({tag, ".out0"}, {bus0.busy, bus0.done, bus0.pass, bus0.first_err_valid,
            bus0.first_err_cin, |bus0.vec_count, |bus0.err_count, |bus0.first_err_index,
            |bus0.first_err_a, |bus0.first_err_b, |bus0.first_err_s_duv, |bus0.first_err_s_ref}, 0);
    endtask

    // Presents NV vectors (kinds[i] per index, optional bubbles after index
    // bub_at), checking that done is still low just before the last one.
    task automatic run_kinds(string tag, int kinds[NV], int bub_at, int n_bub);
        for (int i = 0; i < NV - 1; i++) begin
            drive(mk_vec(kinds[i]), 1'b1);
            if (i == bub_at)
                for (int k = 0; k < n_bub; k++) drive(mk_vec(1), 1'b0);
        end
        @(negedge clk);
        chk({tag, ".pre_done1"}, bus1.done, 1'b0);
        chk({tag, ".pre_done0"}, bus0.done, 1'b0);
        put(mk_vec(kinds[NV-1]), 1'b1, 1'b0);
        drive(mk_vec(1), 1'b0);
        check_state(tag, 1);
        check_state(tag, 0);
    endtask

    initial begin
        int kinds[NV];
        vec_t v;

        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // valid without start must be ignored in IDLE
        for (int i = 0; i < 5; i++) drive(mk_vec(1), 1'b1);
        drive(mk_vec(0), 1'b0);
        check_zero("idle");

        do_start();
        kinds = '{default: 0};
        run_kinds("clean", kinds, -1, 0);

        // single error at index 3 with two bubbles mid-run
        do_start();
        for (int i = 0; i < NV - 1; i++) begin
            v = mk_vec(0);
            if (i == 3) begin
                v.a = 32'h0000FFFF; v.b = 32'h00000001; v.cin = 1'b0;
                v.s_ref = 32'h00010000; v.s_duv = 32'h00000000;
                v.cout_ref = 1'b0; v.cout_duv = 1'b0;
            end
            drive(v, 1'b1);
            if (i == 4) begin drive(mk_vec(2), 1'b0); drive(mk_vec(1), 1'b0); end
        end
        drive(mk_vec(0), 1'b1);
        drive(mk_vec(0), 1'b0);
        check_state("single", 1);
        check_state("single", 0);
        chk("single.idx_const", bus1.first_err_index, 3);
        chk("single.sduv_const", bus1.first_err_s_duv, 32'h00000000);

        // cout-only error at 1, gen-only error at 5
        do_start();
        for (int i = 0; i < NV; i++) begin
            drive(mk_vec(i == 1 ? 2 : (i == 5 ? 4 : 0)), 1'b1);
            if (i == 3) begin
                drive(mk_vec(0), 1'b0);
                check_state("multi_mid", 1);
            end
        end
        drive(mk_vec(0), 1'b0);
        check_state("multi", 1);
        check_state("multi", 0);
        chk("multi.err_t1", bus1.err_count, 2);
        chk("multi.err_t0", bus0.err_count, 1);
        chk("multi.idx_t1", bus1.first_err_index, 1);

        for (int r = 0; r < 4; r++) begin
            do_start();
            for (int i = 0; i < NV; i++) begin
                int k;
                k = $urandom_range(0, 9);
                kinds[i] = (k > 4) ? 0 : k;
            end
            run_kinds($sformatf("rand%0d", r), kinds, $urandom_range(0, NV-2), $urandom_range(0, 3));
        end

        // DONE holds its result while valid keeps arriving
        for (int i = 0; i < 3; i++) drive(mk_vec(1), 1'b1);
        drive(mk_vec(0), 1'b0);
        check_state("done_hold", 1);
        check_state("done_hold", 0);

        do_start();
        drive(mk_vec(0), 1'b0);
        check_state("restart", 1);
        check_state("restart", 0);
        drive(mk_vec(2), 1'b1);
        drive(mk_vec(0), 1'b1);
        drive(mk_vec(1), 1'b1, 1'b1);
        drive(mk_vec(0), 1'b1);
        drive(mk_vec(0), 1'b0);
        check_state("start_ign", 1);
        check_state("start_ign", 0);

        // asynchronous reset between clock edges
        #1 rst_n = 1'b0;
        in_run = 1'b0;
        run_q.delete();
        #1 check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk_vec(0), 1'b0);
        check_zero("post_rst");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
